// File: rtl/masked_aes_pkg.sv
// Shared types and constants for the masked AES control slice.
// Holds the scheduler FSM encoding and job-size limits.
package masked_aes_pkg;

  localparam int LAT_DEF  = 5;
  localparam int NMAX_DEF = 20;
  localparam int IDX_W    = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } sched_state_e;

  // Zero or oversize requests fall back to a full job.
  function automatic logic [IDX_W-1:0] clamp_n(
    input logic [IDX_W-1:0] v,
    input logic [IDX_W-1:0] nmax
  );
    if (v == '0 || v > nmax) return nmax;
    return v;
  endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Valid bit plus byte-index shift line that mirrors the S-box pipeline.
// Shifts only on enable; clr drops every tag in flight.
module tag_delay_line #(
  parameter int LAT = 5,
  parameter int W   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           clr,
  input  logic           d_vld,
  input  logic [W-1:0]   d_idx,
  output logic [LAT-1:0] q_vld,
  output logic [W-1:0]   q_idx
);

  logic [LAT-1:0][W-1:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld <= '0;
      idx_q <= '0;
    end else if (clr) begin
      q_vld <= '0;
      idx_q <= '0;
    end else if (en) begin
      q_vld <= {q_vld[LAT-2:0], d_vld};
      idx_q <= {idx_q[LAT-2:0], d_idx};
    end
  end

  assign q_idx = idx_q[LAT-1];

endmodule

// File: rtl/sbox_pipe_sched.sv
// Issue/drain scheduler for the masked S-box pipeline.
// Gates share registers on fresh randomness and consumer back-pressure.
module sbox_pipe_sched
  import masked_aes_pkg::*;
#(
  parameter int LAT  = LAT_DEF,
  parameter int NMAX = NMAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] cfg_nbytes,
  input  logic             rnd_valid,
  output logic             rnd_ack,
  output logic             pipe_en,
  output logic             issue_valid,
  output logic [IDX_W-1:0] issue_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  sched_state_e     state_q;
  sched_state_e     state_d;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] n_q;
  logic [LAT-1:0]   vld;
  logic [IDX_W-1:0] tail_idx;
  logic             issue;
  logic             drained;
  logic             accept;

  assign pipe_en = rnd_valid & (~vld[LAT-1] | out_ready);
  // Randomness is never reported consumed while held in reset.
  assign rnd_ack = pipe_en & rst_n;

  assign issue = pipe_en & (state_q == S_RUN)
               & (cnt_q < n_q) & ~abort;
  assign accept = (state_q == S_IDLE) & start & ~abort;

  assign issue_valid = issue;
  assign issue_idx   = cnt_q;
  assign out_valid   = vld[LAT-1] & rnd_valid;
  assign out_idx     = tail_idx;

  // Empty after this cycle's shift, so done follows the last result.
  assign drained = pipe_en ? ~|vld[LAT-2:0] : ~|vld;

  assign busy = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done = (state_q == S_DONE) & ~abort;

  tag_delay_line #(
    .LAT (LAT),
    .W   (IDX_W)
  ) u_tags (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pipe_en),
    .clr   (abort),
    .d_vld (issue),
    .d_idx (cnt_q),
    .q_vld (vld),
    .q_idx (tail_idx)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (issue && (cnt_q + 5'd1 == n_q))
                 state_d = S_DRAIN;
      S_DRAIN: if (drained) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      n_q   <= '0;
    end else if (abort) begin
      cnt_q <= '0;
      n_q   <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      n_q   <= clamp_n(cfg_nbytes, IDX_W'(NMAX));
    end else if (issue) begin
      cnt_q <= cnt_q + 5'd1;
    end
  end

endmodule
